// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter, receiver and receive FIFO.
package uart_pkg;
    localparam int UART_DATA_W       = 8;
    localparam int RX_FIFO_DEPTH     = 16;
    localparam int RX_FIFO_AF_MARGIN = 4;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side strobe and consumer valid/ready handshake of the receive FIFO.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = RX_FIFO_DEPTH
);
    logic [DATA_W-1:0]      rx_d_i;
    logic                   rx_done_i;
    logic                   clear_i;
    logic                   ready_i;
    logic [DATA_W-1:0]      d_o;
    logic                   valid_o;
    logic [$clog2(DEPTH):0] level_o;
    logic                   almost_full_o;
    logic                   overflow_o;

    modport master (
        output rx_d_i, rx_done_i, clear_i, ready_i,
        input  d_o, valid_o, level_o, almost_full_o, overflow_o
    );
    modport slave (
        input  rx_d_i, rx_done_i, clear_i, ready_i,
        output d_o, valid_o, level_o, almost_full_o, overflow_o
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through buffer for received bytes with RTS almost-full
// and a sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = RX_FIFO_DEPTH,
    parameter int AF_MARGIN = RX_FIFO_AF_MARGIN
) (
    input  logic          clk,
    input  logic          resetn,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_MARGIN <= 0 || AF_MARGIN >= DEPTH) begin : g_bad_margin
        $error("uart_rx_fifo: AF_MARGIN must satisfy 0 < AF_MARGIN < DEPTH");
    end

    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
    logic        full, empty, push, pop, drop, af_q, ovf_q;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = bus.rx_done_i && (!full || pop) && !bus.clear_i;
    assign drop    = bus.rx_done_i && full && !pop;
    assign wr_nxt  = wr_ptr + (AW+1)'(push);
    assign rd_nxt  = bus.clear_i ? wr_ptr : rd_ptr + (AW+1)'(pop);
    assign lvl_nxt = wr_nxt - rd_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            af_q   <= lvl_nxt >= (AW+1)'(DEPTH - AF_MARGIN);
            ovf_q  <= bus.clear_i ? 1'b0 : (ovf_q || drop);
        end
    end

    sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.rx_d_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.d_o)
    );

    assign bus.valid_o       = !empty;
    assign bus.level_o       = wr_ptr - rd_ptr;
    assign bus.almost_full_o = af_q;
    assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo (DEPTH=16, AF_MARGIN=4).
module tb_uart_rx_fifo;
    logic clk;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] q[$];
    bit   exp_ovf;

    uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AF_MARGIN(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock of stimulus; the scoreboard predicts acceptance, drops and the post-edge state.
    task automatic step(input string tag, input bit done, input logic [7:0] d, input bit rdy, input bit clr);
        int sz;
        bit pop_e;
        bus.rx_d_i    = d;
        bus.rx_done_i = done;
        bus.ready_i   = rdy;
        bus.clear_i   = clr;
        sz    = q.size();
        pop_e = (sz > 0) && rdy;
        if (pop_e && !clr) begin
            checks++;
            if (bus.d_o !== q[0]) begin
                errors++;
                $display("FAIL %s pop data: got %02h want %02h", tag, bus.d_o, q[0]);
            end
            void'(q.pop_front());
        end
        if (clr) begin
            q.delete();
            exp_ovf = 1'b0;
        end else if (done) begin
            if (sz < 16 || pop_e) q.push_back(d);
            else exp_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.rx_done_i = 1'b0;
        bus.ready_i   = 1'b0;
        bus.clear_i   = 1'b0;
        checks += 4;
        if (bus.level_o !== 5'(q.size())) begin
            errors++;
            $display("FAIL %s level: got %0d want %0d", tag, bus.level_o, q.size());
        end
        if (bus.valid_o !== (q.size() > 0)) begin
            errors++;
            $display("FAIL %s valid: got %b want %b", tag, bus.valid_o, q.size() > 0);
        end
        if (bus.almost_full_o !== (q.size() >= 12)) begin
            errors++;
            $display("FAIL %s almost_full: got %b want %b", tag, bus.almost_full_o, q.size() >= 12);
        end
        if (bus.overflow_o !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", tag, bus.overflow_o, exp_ovf);
        end
        if (q.size() > 0) begin
            checks++;
            if (bus.d_o !== q[0]) begin
                errors++;
                $display("FAIL %s head: got %02h want %02h", tag, bus.d_o, q[0]);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() > 0; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d entries left want 0", tag, q.size());
        end
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.rx_d_i    = '0;
        bus.rx_done_i = 1'b0;
        bus.clear_i   = 1'b0;
        bus.ready_i   = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        #12;
        checks += 4;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", bus.valid_o); end
        if (bus.level_o !== 5'd0) begin errors++; $display("FAIL reset level: got %0d want 0", bus.level_o); end
        if (bus.almost_full_o !== 1'b0) begin errors++; $display("FAIL reset almost_full: got %b want 0", bus.almost_full_o); end
        if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", bus.overflow_o); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        step("single_push", 1'b1, 8'hA5, 1'b0, 1'b0);
        step("single_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        drain("fill_drain");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step("ovf_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step("ovf_drop", 1'b1, 8'h55, 1'b0, 1'b0);
        step("ovf_push_pop_full", 1'b1, 8'h55, 1'b1, 1'b0);
        drain("ovf_drain");
    endtask

    task automatic test_random();
        step("rand_clear", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++)
            step("rand", 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        drain("rand_drain");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 17; i++) step("clr_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step("clr_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_with_byte", 1'b1, 8'hEE, 1'b0, 1'b1);
        step("clr_idle", 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) step("ar_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        checks += 3;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL async_reset valid: got %b want 0", bus.valid_o); end
        if (bus.level_o !== 5'd0) begin errors++; $display("FAIL async_reset level: got %0d want 0", bus.level_o); end
        if (bus.almost_full_o !== 1'b0) begin errors++; $display("FAIL async_reset almost_full: got %b want 0", bus.almost_full_o); end
        q.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        step("ar_push", 1'b1, 8'h3C, 1'b0, 1'b0);
        step("ar_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_random();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
